// File: rtl/regfile_writer.sv
// regfile_writer: 32 x 32-bit register file with a byte-enabled write port
// and a sequential clear that zeroes one register per cycle.
//
// Write handshake: a write is accepted at a rising edge of clk where
// wr_valid and wr_ready are both 1. wr_ready is combinational: it is 1 only
// in IDLE, with clr_req low and rst_n high. The address, data and byte enables
// are sampled only on an accepting edge. wr_valid may be asserted without
// waiting for wr_ready.
module regfile_writer #(
    parameter bit ZERO_REG = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [4:0]    wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [3:0]    wr_be,
    input  logic          clr_req,
    output logic          busy,
    output logic [1023:0] regs_flat,
    output logic [15:0]   wr_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  clr_idx;
    logic [31:0] regs [32];
    logic        wr_fire;
    logic        wr_blocked;

    assign wr_fire    = wr_valid && wr_ready;
    // Register 0 stays zero when it is hardwired; the write is still accepted.
    assign wr_blocked = ZERO_REG && (wr_addr == 5'd0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: IDLE enters CLEAR on clr_req; CLEAR ends after index 31.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clr_req) state_nxt = CLEAR;
            CLEAR:   if (clr_idx == 5'd31) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; wr_ready also held low during reset.
    always_comb begin
        wr_ready = rst_n && (state == IDLE) && !clr_req;
        busy     = (state == CLEAR);
    end

    // Clear index: parked at 0 in IDLE so every clear starts at register 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             clr_idx <= 5'd0;
        else if (state == IDLE) clr_idx <= 5'd0;
        else                    clr_idx <= clr_idx + 5'd1;
    end

    // Accepted-write counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       wr_count <= 16'd0;
        else if (wr_fire) wr_count <= wr_count + 16'd1;
    end

    // Register storage: clear zeroes one entry per cycle, otherwise byte writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 32; k++) regs[k] <= 32'd0;
        end else if (state == CLEAR) begin
            regs[clr_idx] <= 32'd0;
        end else if (wr_fire && !wr_blocked) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) regs[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // Flops drive the read-mux inputs directly.
    for (genvar k = 0; k < 32; k++) begin : g_flat
        assign regs_flat[32*k +: 32] = regs[k];
    end

endmodule

// File: tb/tb_regfile_writer.sv
// Directed bench for regfile_writer with a scoreboard on accepted writes.
module tb_regfile_writer;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [4:0]    wr_addr = '0;
    logic [31:0]   wr_data = '0;
    logic [3:0]    wr_be = '0;
    logic          clr_req = 1'b0;
    logic          busy;
    logic [1023:0] regs_flat;
    logic [15:0]   wr_count;

    always #5 clk = ~clk;

    regfile_writer #(.ZERO_REG(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .clr_req   (clr_req),
        .busy      (busy),
        .regs_flat (regs_flat),
        .wr_count  (wr_count)
    );

    // ---------------- scoreboard ----------------
    // Entry: {addr[4:0], expected register value[31:0], expected wr_count[15:0]}
    logic [52:0] exp_q[$];
    logic [15:0] exp_count;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (regs_flat !== '0) begin
            failures++;
            $display("FAIL %s: regs_flat not all zero", name);
        end
    endtask

    function automatic logic [31:0] reg_at(input logic [4:0] a);
        return regs_flat[32*a +: 32];
    endfunction

    // Monitor: on every accepting edge, pop the expected entry and compare.
    always @(posedge clk) begin
        logic [4:0]  a;
        logic [52:0] e;
        if (rst_n && wr_valid && wr_ready) begin
            a = wr_addr;
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_accept: addr %0d accepted, none expected", a);
            end else begin
                e = exp_q.pop_front();
                check("accept_addr", {59'd0, a}, {59'd0, e[52:48]});
                check("reg_value", {32'd0, reg_at(a)}, {32'd0, e[47:16]});
                check("wr_count", {48'd0, wr_count}, {48'd0, e[15:0]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        wr_valid = 1'b0;
        clr_req = 1'b0;
        #1;
        check_all_zero("reset_regs");
        check("reset_count", {48'd0, wr_count}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_ready", {63'd0, wr_ready}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = 16'd0;
        #1;
        check("post_reset_ready", {63'd0, wr_ready}, 64'd1);
    endtask

    // Leaves wr_valid high; caller ends a burst with idle().
    task automatic write(input logic [4:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic [31:0] ev);
        @(negedge clk);
        check("ready_before_write", {63'd0, wr_ready}, 64'd1);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        wr_be    = be;
        exp_count = exp_count + 16'd1;
        exp_q.push_back({a, ev, exp_count});
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic load_all();
        for (int k = 0; k < 32; k++) begin
            write(5'(k), 32'h1000_0000 + k, 4'hF, (k == 0) ? 32'd0 : 32'h1000_0000 + k);
        end
        idle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int ready_bad;
        exp_count = 16'd0;

        // Register 0 is hardwired; write still counts and ready stays up.
        do_reset();
        write(5'd0, 32'hFFFF_FFFF, 4'hF, 32'd0);
        idle();
        #1;
        check("zero_reg_ready", {63'd0, wr_ready}, 64'd1);
        check("zero_reg_value", {32'd0, reg_at(5'd0)}, 64'd0);

        // Full write then partial byte write; then all-disabled byte enables.
        do_reset();
        write(5'd5, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF);
        write(5'd5, 32'h0000_0011, 4'b0001, 32'hDEAD_BE11);
        write(5'd5, 32'h0000_0000, 4'b0000, 32'hDEAD_BE11);
        write(5'd6, 32'hAABB_CCDD, 4'b1010, 32'hAA00_CC00);
        idle();

        // Load all, then clear with a colliding write to addr 3.
        do_reset();
        load_all();
        @(negedge clk);
        clr_req  = 1'b1;
        wr_valid = 1'b1;
        wr_addr  = 5'd3;
        wr_data  = 32'h0;
        wr_be    = 4'hF;
        #1;
        check("clr_ready_low", {63'd0, wr_ready}, 64'd0);
        check("clr_busy_before", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
        check("clr_reg3_kept", {32'd0, reg_at(5'd3)}, 64'h1000_0003);
        check("clr_count_kept", {48'd0, wr_count}, {48'd0, exp_count});
        n = 0;
        ready_bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (c == 3) clr_req = 1'b0;
            if (!busy) begin
                wr_valid = 1'b0;
                break;
            end
            n++;
            if (wr_ready) ready_bad++;
        end
        check("clear_busy_cycles", 64'(n), 64'd32);
        check("clear_ready_low_cycles", 64'(ready_bad), 64'd0);
        wr_valid = 1'b0;
        #1;
        check_all_zero("clear_result");
        check("clear_count", {48'd0, wr_count}, {48'd0, exp_count});
        check("clear_ready_after", {63'd0, wr_ready}, 64'd1);

        // Reset asserted between CLEAR edges 10 and 11.
        load_all();
        @(negedge clk);
        clr_req = 1'b1;
        @(posedge clk);
        clr_req = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_clear_reset_regs");
        check("mid_clear_reset_count", {48'd0, wr_count}, 64'd0);
        check("mid_clear_reset_busy", {63'd0, busy}, 64'd0);
        check("mid_clear_reset_ready", {63'd0, wr_ready}, 64'd0);
        #1;
        rst_n = 1'b1;
        exp_count = 16'd0;
        @(negedge clk);
        check("after_abort_busy", {63'd0, busy}, 64'd0);
        check("after_abort_ready", {63'd0, wr_ready}, 64'd1);
        write(5'd31, 32'hCAFE_F00D, 4'hF, 32'hCAFE_F00D);
        idle();
        #1;
        check("after_abort_reg20", {32'd0, reg_at(5'd20)}, 64'd0);

        // 65537 back-to-back writes: counter wraps to 1.
        do_reset();
        for (int i = 0; i < 65537; i++) begin
            write(5'd7, 32'(i), 4'hF, 32'(i));
        end
        idle();
        #1;
        check("wrap_count", {48'd0, wr_count}, 64'd1);
        check("wrap_reg7", {32'd0, reg_at(5'd7)}, 64'd65536);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_writer.md
REGFILE_WRITER -- requirements
Module: regfile_writer

Interface
REQ-001 Parameter ZERO_REG, default 1, meaning: when 1, register 0 is hardwired to zero and ignores writes.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 wr_valid  input  1  write request valid.
REQ-005 wr_ready  output  1  write request can be accepted this cycle.
REQ-006 wr_addr  input  5  target register index 0..31.
REQ-007 wr_data  input  32  write data.
REQ-008 wr_be  input  4  byte enables; bit k enables wr_data[8k+7:8k].
REQ-009 clr_req  input  1  request to zero all 32 registers.
REQ-010 busy  output  1  high while the clear sequence runs.
REQ-011 regs_flat  output  1024  register contents; register k on bits [32k+31:32k]; feeds the 32-to-1 read mux inputs I0..I31.
REQ-012 wr_count  output  16  count of accepted writes, including masked-out and register-0 writes.

Function
REQ-013 The block SHALL hold 32 registers of 32 bits each, driven continuously and directly from flops onto regs_flat.
REQ-014 The FSM SHALL have exactly two states: IDLE and CLEAR.
REQ-015 wr_ready SHALL be a combinational function: 1 iff state is IDLE and clr_req is 0.
REQ-016 A write is accepted at a rising edge where wr_valid and wr_ready are both 1.
REQ-017 On acceptance, each byte of register wr_addr with its wr_be bit set SHALL take the corresponding wr_data byte; bytes with wr_be 0 keep their value.
REQ-018 Write latency SHALL be one edge: the new value appears on regs_flat immediately after the accepting edge.
REQ-019 With ZERO_REG=1, a write to address 0 SHALL be accepted, SHALL increment wr_count, and SHALL leave register 0 at 0.
REQ-020 wr_be=4'b0000 SHALL complete the handshake and increment wr_count without changing any register.
REQ-021 wr_count SHALL increment by 1 per accepted write and wrap from 16'hFFFF to 0.
REQ-022 IDLE with clr_req=1 at an edge SHALL cause a transition to CLEAR with the clear index at 0; a simultaneous wr_valid is not accepted, because wr_ready is 0.
REQ-023 In CLEAR, each edge SHALL zero register[index] and increment the index by 1.
REQ-024 The edge that zeroes register 31 SHALL return the FSM to IDLE, so CLEAR lasts exactly 32 cycles.
REQ-025 busy SHALL be 1 exactly while in CLEAR; wr_ready SHALL be 0 throughout CLEAR.
REQ-026 clr_req asserted during CLEAR SHALL be ignored and SHALL NOT restart or extend the sequence.
REQ-027 A register's value SHALL be unchanged except by an accepted write or the clear sequence.
REQ-028 wr_addr, wr_data and wr_be SHALL be don't-care when a write is not accepted.

Reset
REQ-029 rst_n low SHALL immediately, without waiting for a clock edge, set all 32 registers to 0, wr_count to 0, the FSM to IDLE and the clear index to 0.
REQ-030 While rst_n is low, busy SHALL be 0 and wr_ready SHALL be 0.
REQ-031 After rst_n deasserts, wr_ready SHALL follow REQ-015 from the first edge.
REQ-032 Reset asserted mid-CLEAR SHALL abort the sequence, zero all state, and leave the FSM in IDLE after release.

Verification
REQ-033 Write addr 5, data 32'hDEADBEEF, be 4'hF, then addr 5, data 32'h00000011, be 4'b0001 -> reg5 = 32'hDEADBE11 and wr_count = 2.
REQ-034 Write addr 0, data 32'hFFFFFFFF, be 4'hF with ZERO_REG=1 -> reg0 stays 0, wr_count = 1, wr_ready stays 1.
REQ-035 Load all 32 registers with 32'h1000_0000+k, then pulse clr_req -> busy high for exactly 32 cycles, wr_ready low for the same 32 cycles, and all registers read 0 afterwards.
REQ-036 Assert clr_req and wr_valid (addr 3) in the same cycle -> write not accepted, reg3 unchanged until cleared, wr_count unchanged.
REQ-037 Drop rst_n asynchronously between edges 10 and 11 of CLEAR -> all outputs are 0 immediately; after release busy=0, wr_ready=1 and a write to addr 31 succeeds on the next edge.
REQ-038 Perform 65537 back-to-back writes -> wr_count = 1 and wr_ready remains 1 on every cycle.
